// File: rtl/sbox_scheduler_if.sv
// Request/grant/result bundle between the two S-box requesters (cipher state, key expansion)
// and the shared sbox_scheduler.
interface sbox_scheduler_if;
    logic         st_req;
    logic [127:0] st_in;
    logic         st_gnt;
    logic [127:0] st_out;
    logic         st_done;
    logic         ks_req;
    logic [31:0]  ks_in;
    logic         ks_gnt;
    logic [31:0]  ks_out;
    logic         ks_done;
    logic         busy;

    modport master (
        output st_req, st_in, ks_req, ks_in,
        input  st_gnt, st_out, st_done, ks_gnt, ks_out, ks_done, busy
    );

    modport slave (
        input  st_req, st_in, ks_req, ks_in,
        output st_gnt, st_out, st_done, ks_gnt, ks_out, ks_done, busy
    );
endinterface

// File: rtl/sbox_scheduler.sv
// Shared SubBytes engine: four AES forward S-box units time-multiplexed between the
// round datapath (128-bit state, one column per cycle) and the key expansion (one word).
module sbox_scheduler #(
    parameter int ARB_MODE = 0
) (
    input  logic            clk,
    input  logic            rst,
    sbox_scheduler_if.slave bus
);

    // Byte x of the table sits at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, ST_RUN, KS_RUN} state_t;
    typedef enum logic {GNT_ST, GNT_KS} gnt_t;

    state_t           state;
    state_t           state_nxt;
    gnt_t             last_gnt;
    logic [1:0]       col_cnt;
    logic [3:0][31:0] st_lat;
    logic [3:0][31:0] st_res;
    logic [31:0]      ks_lat;
    logic [31:0]      ks_res;
    logic             st_done_q;
    logic             ks_done_q;
    logic             st_gnt_c;
    logic             ks_gnt_c;
    logic [31:0]      unit_in;
    logic [31:0]      unit_out;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [2047:0] sh;
        sh = SBOX_TABLE << {b, 3'b000};
        return sh[2047:2040];
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_unit
        assign unit_out[8*i +: 8] = sbox(unit_in[8*i +: 8]);
    end

    // Column 0 is the most significant word, so packed index 3 - col_cnt == ~col_cnt.
    always_comb begin
        st_gnt_c  = 1'b0;
        ks_gnt_c  = 1'b0;
        state_nxt = state;
        unit_in   = ks_lat;
        case (state)
            IDLE: begin
                if (bus.st_req && bus.ks_req) begin
                    if (ARB_MODE == 0 || last_gnt == GNT_ST) ks_gnt_c = 1'b1;
                    else                                     st_gnt_c = 1'b1;
                end else begin
                    st_gnt_c = bus.st_req;
                    ks_gnt_c = bus.ks_req;
                end
                if (st_gnt_c)      state_nxt = ST_RUN;
                else if (ks_gnt_c) state_nxt = KS_RUN;
            end
            ST_RUN: begin
                unit_in = st_lat[~col_cnt];
                if (col_cnt == 2'd3) state_nxt = IDLE;
            end
            KS_RUN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Done pulses are registered so they land in the IDLE cycle, allowing a same-cycle regrant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt  <= GNT_ST;
            col_cnt   <= 2'd0;
            st_lat    <= '0;
            ks_lat    <= '0;
            st_res    <= '0;
            ks_res    <= '0;
            st_done_q <= 1'b0;
            ks_done_q <= 1'b0;
        end else begin
            st_done_q <= 1'b0;
            ks_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (st_gnt_c) begin
                        st_lat   <= bus.st_in;
                        col_cnt  <= 2'd0;
                        last_gnt <= GNT_ST;
                    end else if (ks_gnt_c) begin
                        ks_lat   <= bus.ks_in;
                        last_gnt <= GNT_KS;
                    end
                end
                ST_RUN: begin
                    st_res[~col_cnt] <= unit_out;
                    col_cnt          <= col_cnt + 2'd1;
                    st_done_q        <= (col_cnt == 2'd3);
                end
                KS_RUN: begin
                    ks_res    <= unit_out;
                    ks_done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.st_gnt  = st_gnt_c;
    assign bus.ks_gnt  = ks_gnt_c;
    assign bus.st_out  = st_res;
    assign bus.ks_out  = ks_res;
    assign bus.st_done = st_done_q;
    assign bus.ks_done = ks_done_q;
    assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_sbox_scheduler.sv
// Bench for sbox_scheduler: one fixed-priority and one round-robin instance driven by queued
// requester agents, checked every cycle against a transaction-level timing/arbitration model.
module tb_sbox_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sbox_scheduler_if bus0 ();
    sbox_scheduler_if bus1 ();

    sbox_scheduler #(.ARB_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sbox_scheduler #(.ARB_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Requester slot id = 2*instance + (0 for ST, 1 for KS).
    logic         reqv [4] = '{default: 1'b0};
    logic [127:0] datv [4] = '{default: '0};

    assign bus0.st_req = reqv[0];
    assign bus0.st_in  = datv[0];
    assign bus0.ks_req = reqv[1];
    assign bus0.ks_in  = datv[1][31:0];
    assign bus1.st_req = reqv[2];
    assign bus1.st_in  = datv[2];
    assign bus1.ks_req = reqv[3];
    assign bus1.ks_in  = datv[3][31:0];

    typedef struct {
        logic [127:0] data;
        int           gap;
        int           hold;
    } txn_t;

    txn_t txq [4][$];
    bit   agentBusy [4] = '{default: 1'b0};

    logic [7:0]   sref [256];
    int           free_at [2];
    int           st_g [2];
    int           st_done_at [2];
    int           ks_done_at [2];
    logic [127:0] st_prev [2];
    logic [127:0] st_new [2];
    logic [31:0]  ks_prev [2];
    logic [31:0]  ks_new [2];
    bit           last_ks [2];

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic buildSbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sref[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                          ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] subBytes(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sref[v[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sref[v[8*i +: 8]];
        return r;
    endfunction

    // Column c of a new result becomes visible 2+c cycles after its grant cycle.
    function automatic logic [127:0] stView(input int d, input int n);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            r[127-32*c -: 32] = (n >= st_g[d] + 2 + c) ? st_new[d][127-32*c -: 32]
                                                       : st_prev[d][127-32*c -: 32];
        return r;
    endfunction

    function automatic logic [31:0] ksView(input int d, input int n);
        return (n >= ks_done_at[d]) ? ks_new[d] : ks_prev[d];
    endfunction

    task automatic modelReset(input int d);
        free_at[d]    = cyc;
        st_g[d]       = -100;
        st_done_at[d] = -100;
        ks_done_at[d] = -100;
        st_prev[d]    = '0;
        st_new[d]     = '0;
        ks_prev[d]    = '0;
        ks_new[d]     = '0;
        last_ks[d]    = 1'b0;
    endtask

    task automatic modelStep(input int d, input bit inReset,
                             input logic sr, input logic [127:0] sin,
                             input logic kr, input logic [31:0] kin,
                             input logic sg, input logic kg,
                             input logic [127:0] sout, input logic sdone,
                             input logic [31:0] kout, input logic kdone, input logic busy);
        int    n;
        bit    egS;
        bit    egK;
        string p;
        n   = cyc;
        egS = 1'b0;
        egK = 1'b0;
        p   = (d == 0) ? "fixed" : "rr";
        if (inReset) begin
            modelReset(d);
        end else begin
            if (n >= free_at[d]) begin
                if (sr && kr) begin
                    if (d == 0 || !last_ks[d]) egK = 1'b1;
                    else                       egS = 1'b1;
                end else begin
                    egS = sr;
                    egK = kr;
                end
            end
            checkOutput($sformatf("%s st_gnt", p), 128'(sg), 128'(egS));
            checkOutput($sformatf("%s ks_gnt", p), 128'(kg), 128'(egK));
        end
        checkOutput($sformatf("%s busy", p), 128'(busy), 128'(n < free_at[d]));
        checkOutput($sformatf("%s st_done", p), 128'(sdone), 128'(n == st_done_at[d]));
        checkOutput($sformatf("%s ks_done", p), 128'(kdone), 128'(n == ks_done_at[d]));
        checkOutput($sformatf("%s st_out", p), sout, stView(d, n));
        checkOutput($sformatf("%s ks_out", p), 128'(kout), 128'(ksView(d, n)));
        if (egS) begin
            st_prev[d]    = stView(d, n);
            st_new[d]     = subBytes(sin);
            st_g[d]       = n;
            st_done_at[d] = n + 5;
            free_at[d]    = n + 5;
            last_ks[d]    = 1'b0;
        end else if (egK) begin
            ks_prev[d]    = ksView(d, n);
            ks_new[d]     = subWord(kin);
            ks_done_at[d] = n + 2;
            free_at[d]    = n + 2;
            last_ks[d]    = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        modelStep(0, rst, bus0.st_req, bus0.st_in, bus0.ks_req, bus0.ks_in, bus0.st_gnt,
                  bus0.ks_gnt, bus0.st_out, bus0.st_done, bus0.ks_out, bus0.ks_done, bus0.busy);
        modelStep(1, rst, bus1.st_req, bus1.st_in, bus1.ks_req, bus1.ks_in, bus1.st_gnt,
                  bus1.ks_gnt, bus1.st_out, bus1.st_done, bus1.ks_out, bus1.ks_done, bus1.busy);
    end

    function automatic logic gntOf(input int id);
        case (id)
            0:       return bus0.st_gnt;
            1:       return bus0.ks_gnt;
            2:       return bus1.st_gnt;
            default: return bus1.ks_gnt;
        endcase
    endfunction

    // Requester: idle gap, then hold req/data until granted or the hold budget runs out.
    task automatic agent(input int id);
        txn_t t;
        bit   got;
        @(posedge clk); #1;
        forever begin
            if (txq[id].size() == 0) begin
                @(posedge clk); #1;
            end else begin
                t = txq[id].pop_front();
                agentBusy[id] = 1'b1;
                repeat (t.gap) begin @(posedge clk); #1; end
                reqv[id] = 1'b1;
                datv[id] = t.data;
                got = 1'b0;
                for (int c = 0; c < t.hold && !got; c++) begin
                    @(negedge clk);
                    got = gntOf(id) && !rst;
                    @(posedge clk); #1;
                end
                reqv[id] = 1'b0;
                agentBusy[id] = 1'b0;
            end
        end
    endtask

    initial begin
        fork
            agent(0);
            agent(1);
            agent(2);
            agent(3);
        join_none
    end

    task automatic applyStimulus(input int id, input logic [127:0] data, input int gap, input int hold);
        txn_t t;
        t.data = data;
        t.gap  = gap;
        t.hold = hold;
        txq[id].push_back(t);
    endtask

    task automatic waitQuiet(input int budget);
        bit quiet;
        quiet = 1'b0;
        for (int c = 0; c < budget && !quiet; c++) begin
            @(negedge clk); #1;
            quiet = (cyc >= free_at[0]) && (cyc >= free_at[1]);
            for (int i = 0; i < 4; i++)
                if (txq[i].size() != 0 || agentBusy[i]) quiet = 1'b0;
        end
        checkOutput("drain within budget", 128'(quiet), 128'(1'b1));
    endtask

    localparam logic [127:0] VEC_ST = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] VEC_KS = 128'h09cf4f3c;

    initial begin
        bit got;
        buildSbox();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int d = 0; d < 2; d++) applyStimulus(2*d, VEC_ST, 0, 50);
        waitQuiet(40);
        checkOutput("known st_out fixed", bus0.st_out, 128'h638293c31bfc33f5c4eeacea4bc12816);
        checkOutput("known st_out rr", bus1.st_out, 128'h638293c31bfc33f5c4eeacea4bc12816);

        for (int d = 0; d < 2; d++) applyStimulus(2*d + 1, VEC_KS, 0, 50);
        waitQuiet(40);
        checkOutput("known ks_out fixed", 128'(bus0.ks_out), 128'(32'h018a84eb));
        checkOutput("known ks_out rr", 128'(bus1.ks_out), 128'(32'h018a84eb));

        for (int r = 0; r < 3; r++) begin
            for (int id = 0; id < 4; id++)
                applyStimulus(id, {$urandom, $urandom, $urandom, $urandom}, 0, 50);
            waitQuiet(60);
        end

        for (int k = 0; k < 4; k++)
            for (int id = 0; id < 4; id++)
                applyStimulus(id, {$urandom, $urandom, $urandom, $urandom}, 0, 60);
        waitQuiet(200);

        for (int d = 0; d < 2; d++) begin
            applyStimulus(2*d, VEC_ST, 0, 50);
            applyStimulus(2*d + 1, {$urandom, $urandom, $urandom, $urandom}, 2, 50);
        end
        waitQuiet(60);

        for (int d = 0; d < 2; d++) applyStimulus(2*d, VEC_ST, 0, 50);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = bus0.st_gnt;
        end
        checkOutput("grant before reset", 128'(got), 128'(1'b1));
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset st_out fixed", bus0.st_out, '0);
        checkOutput("async reset st_out rr", bus1.st_out, '0);
        checkOutput("async reset busy fixed", 128'(bus0.busy), '0);
        checkOutput("async reset busy rr", 128'(bus1.busy), '0);
        checkOutput("async reset st_done fixed", 128'(bus0.st_done), '0);
        @(posedge clk);
        #1 rst = 1'b0;
        waitQuiet(40);
        for (int d = 0; d < 2; d++) applyStimulus(2*d, '0, 0, 50);
        waitQuiet(40);
        checkOutput("zero state fixed", bus0.st_out, {16{8'h63}});
        checkOutput("zero state rr", bus1.st_out, {16{8'h63}});

        for (int b = 0; b < 60; b++) begin
            for (int id = 0; id < 4; id++) begin
                int n;
                n = int'($urandom_range(0, 3));
                for (int k = 0; k < n; k++)
                    applyStimulus(id, {$urandom, $urandom, $urandom, $urandom},
                                  int'($urandom_range(0, 3)), int'($urandom_range(1, 12)));
            end
            waitQuiet(400);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
